// File: rtl/display_pkg.sv
// Shared constants and helpers for the hex display scan driver.
package display_pkg;

  localparam int NUM_DIGITS_DEFAULT = 4;

  // Digit enables are active-low on a common-anode display.
  localparam logic DIGIT_OFF = 1'b1;

  // Width of a counter or index covering 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Host-side bundle for the scanner: value load path, blanking and display drive.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS_DEFAULT
);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nibble_out;
  logic [NUM_DIGITS-1:0]   digit_sel_n;
  logic                    frame_tick;
  logic                    busy_pending;

  modport master (
    output value_in, load, blank_mask,
    input  nibble_out, digit_sel_n, frame_tick, busy_pending
  );

  modport slave (
    input  value_in, load, blank_mask,
    output nibble_out, digit_sel_n, frame_tick, busy_pending
  );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running slot counter: counts 0..DIV-1 and flags the last cycle of a slot.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIV = 12000,
  localparam int CW = idx_width(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic          slot_end
);

  logic [CW-1:0] count_q, count_d;

  assign slot_end = (count_q == CW'(DIV - 1));
  assign count    = count_q;

  // Explicit wrap so DIV need not be a power of two.
  always_comb begin
    count_d = slot_end ? '0 : count_q + CW'(1);
  end

  // Slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// A pending buffer absorbs loads; it is copied to the display buffer only
// when the scan wraps to digit 0, so a frame never shows a mix of values.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEFAULT,
  parameter int REFRESH_DIV = 12000,
  parameter int DEADTIME    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_display_scanner_if.slave  bus
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] count;
  logic          slot_end;
  logic          swap;
  logic          in_dead;

  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   pend_q, pend_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic                         busy_q, busy_d;
  logic [3:0]                   nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]        sel_q, sel_d;
  logic                         tick_q, tick_d;

  scan_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .slot_end (slot_end)
  );

  // Dead window at the head of every slot; a zero DEADTIME removes it entirely.
  if (DEADTIME == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (count < CW'(DEADTIME));
  end

  assign swap = slot_end && (idx_q == LAST_IDX);

  // Digit index and double-buffer update; a load coinciding with the swap
  // goes straight to the display so it is not held for a whole extra frame.
  always_comb begin
    idx_d  = idx_q;
    pend_d = pend_q;
    disp_d = disp_q;
    busy_d = busy_q;
    if (slot_end) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    if (swap && busy_q) begin
      disp_d = pend_q;
      busy_d = 1'b0;
    end
    if (bus.load) begin
      pend_d = bus.value_in;
      busy_d = 1'b1;
      if (swap) begin
        disp_d = bus.value_in;
        busy_d = 1'b0;
      end
    end
  end

  // Registered display drive; nibble stays valid through dead time so the
  // segment decoder has settled before the enable lands.
  always_comb begin
    nibble_d = disp_q[idx_q];
    sel_d    = {NUM_DIGITS{DIGIT_OFF}};
    if (!in_dead && !bus.blank_mask[idx_q]) sel_d[idx_q] = ~DIGIT_OFF;
    tick_d   = swap;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      pend_q   <= '0;
      disp_q   <= '0;
      busy_q   <= 1'b0;
      nibble_q <= '0;
      sel_q    <= {NUM_DIGITS{DIGIT_OFF}};
      tick_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
      nibble_q <= nibble_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.nibble_out   = nibble_q;
  assign bus.digit_sel_n  = sel_q;
  assign bus.frame_tick   = tick_q;
  assign bus.busy_pending = busy_q;

endmodule
